// File: rtl/serv_lsu_wb.sv
// serv_lsu_wb - load/store unit between the core datapath and a Wishbone
// data bus. One request is in flight at a time. Store data is shifted onto
// the byte lanes. Load data is shifted back, then sign- or zero-extended.
// Every bus beat is bounded by a wait-cycle timeout.
//
// Optional feature macro: SERV_LSU_SPLIT_EN
//   undefined : a misaligned access traps with o_rsp_misalign and no bus cycle.
//   defined   : an access that crosses a bus word runs as two beats and the
//               load bytes of both beats are merged.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_*/o_req_ready request handshake (addr, we, size, signed, wdata)
//   o_rsp_*             one-cycle response (rdata, err, misalign)
//   o_wb_*/i_wb_*       Wishbone master (adr, dat, sel, we, cyc, rdt, ack)
module serv_lsu_wb #(
  parameter int DW         = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [31:0]     i_req_addr,
  input  logic            i_req_we,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_signed,
  input  logic [DW-1:0]   i_req_wdata,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_misalign,
  output logic [31:0]     o_wb_adr,
  output logic [DW-1:0]   o_wb_dat,
  output logic [DW/8-1:0] o_wb_sel,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  input  logic [DW-1:0]   i_wb_rdt,
  input  logic            i_wb_ack
);
  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);
  localparam logic [NB-1:0] ONE     = NB'(1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr_q;
  logic          we_q, sgn_q, err_q;
  logic [1:0]    size_q;
  logic [DW-1:0] wdata_q, rd0_q, rd1_q;
  logic [CW-1:0] cnt_q;

  logic [OB-1:0] off, noff;
  logic [3:0]    off4, nbytes;
  logic          illegal, misal, trap, split, tmo, beat, accept;
  logic [31:0]   base_adr;
  logic [NB-1:0] lanes, sel0, sel1;
  logic [DW-1:0] dat0, dat1, lo, ext;
  logic          sbit;

  assign off      = addr_q[OB-1:0];
  assign noff     = '0 - off;      // NB-off for any nonzero offset
  assign off4     = 4'(off);
  assign nbytes   = 4'd1 << size_q;
  assign illegal  = (DW == 32) && (size_q == 2'b11);
  assign misal    = |(off4 & (nbytes - 4'd1));

`ifdef SERV_LSU_SPLIT_EN
  assign trap  = illegal;
  assign split = ~illegal && (({1'b0, off4} + {1'b0, nbytes}) > 5'(NB));
`else
  assign trap  = illegal | misal;
  assign split = 1'b0;
`endif

  assign beat     = (state == BEAT0) || (state == BEAT1);
  assign accept   = i_req_valid && (state == IDLE);
  // The counter holds k-1 in the k-th cycle of a beat. The limit therefore
  // lands on the TMO_CYCLES-th cycle. An ack in that same cycle still wins.
  assign tmo      = (TMO_CYCLES != 0) && (cnt_q == CNT_LIM) && !i_wb_ack;
  assign base_adr = {addr_q[31:OB], {OB{1'b0}}};

  // (1<<n)-1 taken modulo 2^NB gives all ones when n == NB.
  assign lanes = (ONE << nbytes) - ONE;
  assign sel0  = lanes << off;
  assign sel1  = (ONE << (off4 + nbytes - 4'(NB))) - ONE;
  assign dat0  = wdata_q << {off, 3'b000};
  assign dat1  = wdata_q >> {noff, 3'b000};

  // Bytes of the second beat sit above the first beat. Shifting the pair
  // right by the offset LSB-justifies the loaded value.
  assign lo = DW'({rd1_q, rd0_q} >> {off, 3'b000});

  always_comb begin
    ext  = '0;
    sbit = 1'b0;
    for (int i = 0; i < NB; i++)
      if (i < int'(nbytes)) begin
        ext[8*i +: 8] = lo[8*i +: 8];
        sbit          = lo[8*i + 7];
      end
    for (int i = 0; i < NB; i++)
      if (i >= int'(nbytes)) ext[8*i +: 8] = {8{sgn_q & sbit}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A trapped request still spends its BEAT0 slot, with cyc held low. Its
  // response then arrives at the same point as the fastest bus access.
  always_comb begin
    state_nxt      = state;
    o_req_ready    = 1'b0;
    o_rsp_valid    = 1'b0;
    o_rsp_err      = 1'b0;
    o_rsp_misalign = 1'b0;
    o_rsp_rdata    = '0;
    o_wb_cyc       = 1'b0;
    o_wb_adr       = '0;
    o_wb_sel       = '0;
    o_wb_dat       = '0;
    o_wb_we        = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = BEAT0;
      end
      BEAT0: begin
        if (trap) state_nxt = RESP;
        else begin
          o_wb_cyc = 1'b1;
          o_wb_adr = base_adr;
          o_wb_sel = sel0;
          o_wb_dat = dat0;
          o_wb_we  = we_q;
          if (i_wb_ack) state_nxt = split ? BEAT1 : RESP;
          else if (tmo) state_nxt = RESP;
        end
      end
      BEAT1: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = base_adr + 32'(NB);
        o_wb_sel = sel1;
        o_wb_dat = dat1;
        o_wb_we  = we_q;
        if (i_wb_ack || tmo) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid    = 1'b1;
        o_rsp_err      = err_q | illegal;
        o_rsp_misalign = trap & ~illegal;
        if (!we_q && !err_q && !trap) o_rsp_rdata = ext;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (beat) cnt_q <= cnt_q + CW'(1);
      if (accept || (state == BEAT0 && state_nxt == BEAT1)) cnt_q <= '0;
      if (accept) begin
        addr_q  <= i_req_addr;
        we_q    <= i_req_we;
        size_q  <= i_req_size;
        sgn_q   <= i_req_signed;
        wdata_q <= i_req_wdata;
        err_q   <= 1'b0;
        rd0_q   <= '0;
        rd1_q   <= '0;
      end
      if (state == BEAT0 && !trap && i_wb_ack) rd0_q <= i_wb_rdt;
      if (state == BEAT1 && i_wb_ack)          rd1_q <= i_wb_rdt;
      if (beat && !trap && tmo)                err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serv_lsu_wb.sv
// tb_serv_lsu_wb - self-checking bench for serv_lsu_wb (DW=32, TMO_CYCLES=4).
// A bus responder acks each beat after a chosen number of wait cycles.
// Observations are compared against a byte-level model of the access.
module tb_serv_lsu_wb;
  localparam int TMO = 4;
`ifdef SERV_LSU_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_req_signed = 1'b0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0, i_wb_rdt = '0;
  logic [1:0]  i_req_size = '0;
  logic        i_wb_ack = 1'b0;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_misalign, o_wb_we, o_wb_cyc;
  logic [31:0] o_rsp_rdata, o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;

  int checks = 0, errors = 0;

  serv_lsu_wb #(.DW(32), .TMO_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_misalign(o_rsp_misalign), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    int              nbeats;
    int              cyc_cnt;
    int              rsp_cyc;
    logic [1:0][31:0] adr;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] dat;
    logic [1:0]       we;
    logic [31:0]      rdata;
    logic             err;
    logic             mis;
    logic             ready_acc;
    logic             ready_after;
    logic             glitch;
  } obs_t;

  function automatic logic [31:0] lmask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Byte-level reference. Byte j of the access lives at address addr+j.
  // Its lane is (o+j)%4 and its beat is (o+j)/4.
  function automatic obs_t model(input logic [31:0] addr, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] wdata, rdt0, rdt1,
                                 input int d0, d1);
    obs_t e;
    int n, o, tot, b, lane, d;
    logic [31:0] val, rb;
    e = '0;
    e.ready_acc = 1'b1;
    e.ready_after = 1'b1;
    e.rsp_cyc = 2;
    n = 1 << size;
    o = int'(addr[1:0]);
    if (size == 2'd3) begin e.err = 1'b1; return e; end
    if ((o % n) != 0 && !SPLIT) begin e.mis = 1'b1; return e; end
    e.nbeats = (o + n > 4) ? 2 : 1;
    tot = 1;
    for (int k = 0; k < 2; k++)
      if (k < e.nbeats) begin
        d = (k == 0) ? d0 : d1;
        if (d >= TMO) begin tot += TMO; e.err = 1'b1; e.nbeats = k + 1; end
        else tot += d + 1;
      end
    e.cyc_cnt = tot - 1;
    e.rsp_cyc = tot;
    val = '0;
    for (int j = 0; j < n; j++) begin
      b = (o + j) / 4;
      lane = (o + j) % 4;
      if (b < e.nbeats) begin
        e.adr[b] = {addr[31:2], 2'b00} + 32'(4 * b);
        e.sel[b][lane] = 1'b1;
        e.dat[b][8*lane +: 8] = wdata[8*j +: 8];
        e.we[b] = we;
        rb = (b == 0) ? rdt0 : rdt1;
        val[8*j +: 8] = rb[8*lane +: 8];
      end
    end
    if (sgn && n == 1)      val = {{24{val[7]}}, val[7:0]};
    else if (sgn && n == 2) val = {{16{val[15]}}, val[15:0]};
    e.rdata = (we || e.err) ? 32'h0 : val;
    return e;
  endfunction

  // Issues one request and plays the bus slave. Beat k is acked after dk
  // wait cycles, and never acked when dk >= TMO. Acks are also sprayed
  // while cyc is low. Nothing is compared here.
  task automatic run_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, rdt0, rdt1,
                         input int d0, d1, output obs_t o);
    int beat, wcnt, d;
    logic prev_cyc, prev_ack, done;
    o = '0;
    @(negedge i_clk);
    o.ready_acc = o_req_ready;
    i_req_valid = 1'b1; i_req_addr = addr; i_req_we = we; i_req_size = size;
    i_req_signed = sgn; i_req_wdata = wdata;
    i_wb_ack = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_wdata = $urandom; i_req_addr = $urandom;
    beat = -1; wcnt = 0; prev_cyc = 1'b0; prev_ack = 1'b0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      i_wb_ack = 1'b0;
      i_wb_rdt = $urandom;
      if (o_wb_cyc) begin
        if (!prev_cyc || prev_ack) begin
          beat++; wcnt = 0;
          if (beat < 2) begin
            o.adr[beat] = o_wb_adr; o.sel[beat] = o_wb_sel;
            o.dat[beat] = o_wb_dat; o.we[beat] = o_wb_we;
          end else o.glitch = 1'b1;
        end else begin
          wcnt++;
          if (beat < 2 && (o_wb_adr !== o.adr[beat] || o_wb_sel !== o.sel[beat] ||
                           o_wb_dat !== o.dat[beat] || o_wb_we !== o.we[beat])) o.glitch = 1'b1;
        end
        o.cyc_cnt++;
        d = (beat == 0) ? d0 : d1;
        if (wcnt == d) begin i_wb_ack = 1'b1; i_wb_rdt = (beat == 0) ? rdt0 : rdt1; end
      end else i_wb_ack = 1'($urandom_range(0, 1));
      prev_cyc = o_wb_cyc;
      prev_ack = o_wb_cyc && i_wb_ack;
      if (o_rsp_valid) begin
        o.rsp_cyc = c; o.rdata = o_rsp_rdata; o.err = o_rsp_err; o.mis = o_rsp_misalign;
        if (o_wb_cyc) o.glitch = 1'b1;
        done = 1'b1;
      end
      @(negedge i_clk);
    end
    i_wb_ack = 1'b0;
    o.nbeats = beat + 1;
    o.ready_after = o_req_ready;
    if (o_rsp_valid) o.glitch = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
    checks++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_misalign, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, o_rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got cyc=%b adr=%h sel=%b rsp=%b want all 0", o_wb_cyc, o_wb_adr, o_wb_sel, o_rsp_valid);
    end
  endtask

  task automatic test_load_byte_signed;
    obs_t o;
    run_req(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80FFFFFF, 32'h0, 1, 0, o);
    checks++; if (o.adr[0] !== 32'h100) begin errors++; $display("FAIL t1_adr got %h want 00000100", o.adr[0]); end
    checks++; if (o.sel[0] !== 4'b1000) begin errors++; $display("FAIL t1_sel got %b want 1000", o.sel[0]); end
    checks++; if (o.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL t1_rdata got %h want ffffff80", o.rdata); end
    checks++; if (o.rsp_cyc !== 3) begin errors++; $display("FAIL t1_latency got %0d want 3", o.rsp_cyc); end
  endtask

  task automatic test_store_half;
    obs_t o;
    run_req(32'h1A2, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.adr[0] !== 32'h1A0) begin errors++; $display("FAIL t2_adr got %h want 000001a0", o.adr[0]); end
    checks++; if (o.sel[0] !== 4'b1100) begin errors++; $display("FAIL t2_sel got %b want 1100", o.sel[0]); end
    checks++; if (o.dat[0] !== 32'hBEEF0000) begin errors++; $display("FAIL t2_dat got %h want beef0000", o.dat[0]); end
    checks++; if (o.we[0] !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL t2_we_err got we=%b err=%b rdata=%h want 1 0 0", o.we[0], o.err, o.rdata); end
  endtask

  task automatic test_misalign;
    obs_t o;
    run_req(32'h202, 1'b0, 2'd2, 1'b0, 32'h0, 32'hAABB0000, 32'h0000CCDD, 0, 0, o);
`ifdef SERV_LSU_SPLIT_EN
    checks++; if (o.adr !== {32'h204, 32'h200}) begin errors++; $display("FAIL t4_adr got %h want 0000020400000200", o.adr); end
    checks++; if (o.sel !== {4'b0011, 4'b1100}) begin errors++; $display("FAIL t4_sel got %b want 00111100", o.sel); end
    checks++; if (o.rdata !== 32'hCCDDAABB || o.mis !== 1'b0) begin
      errors++; $display("FAIL t4_rdata got %h mis=%b want ccddaabb 0", o.rdata, o.mis); end
`else
    checks++; if (o.cyc_cnt !== 0) begin errors++; $display("FAIL t3_nocyc got %0d cyc cycles want 0", o.cyc_cnt); end
    checks++; if (o.rsp_cyc !== 2) begin errors++; $display("FAIL t3_latency got %0d want 2", o.rsp_cyc); end
    checks++; if (o.mis !== 1'b1 || o.err !== 1'b0) begin errors++; $display("FAIL t3_flags got mis=%b err=%b want 1 0", o.mis, o.err); end
`endif
  endtask

  task automatic test_timeout;
    obs_t o;
    run_req(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 32'h0, 20, 0, o);
    checks++; if (o.cyc_cnt !== TMO) begin errors++; $display("FAIL t5_cyc got %0d want %0d", o.cyc_cnt, TMO); end
    checks++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL t5_err got err=%b rdata=%h want 1 0", o.err, o.rdata); end
    checks++; if (o.rsp_cyc !== TMO + 1 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL t5_resp got rsp_cyc=%0d ready=%b want %0d 1", o.rsp_cyc, o.ready_after, TMO + 1); end
    run_req(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 32'h0, TMO - 1, 0, o);
    checks++; if (o.err !== 1'b0 || o.rdata !== 32'h12345678) begin
      errors++; $display("FAIL limit_ack got err=%b rdata=%h want 0 12345678", o.err, o.rdata); end
  endtask

  task automatic test_illegal_size;
    obs_t o;
    run_req(32'h400, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.err !== 1'b1 || o.mis !== 1'b0 || o.cyc_cnt !== 0 || o.rsp_cyc !== 2) begin
      errors++; $display("FAIL illegal got err=%b mis=%b cyc=%0d rsp=%0d want 1 0 0 2", o.err, o.mis, o.cyc_cnt, o.rsp_cyc); end
  endtask

  task automatic test_wrap;
    obs_t o, e;
    run_req(32'hFFFFFFFE, 1'b0, 2'd2, 1'b1, 32'h0, 32'h8899AABB, 32'h11223344, 0, 1, o);
    e = model(32'hFFFFFFFE, 1'b0, 2'd2, 1'b1, 32'h0, 32'h8899AABB, 32'h11223344, 0, 1);
    checks++; if (o.adr !== e.adr || o.nbeats !== e.nbeats) begin
      errors++; $display("FAIL wrap_adr got %h/%0d want %h/%0d", o.adr, o.nbeats, e.adr, e.nbeats); end
    checks++; if (o.rdata !== e.rdata || o.mis !== e.mis || o.rsp_cyc !== e.rsp_cyc) begin
      errors++; $display("FAIL wrap_rsp got %h mis=%b cyc=%0d want %h %b %0d", o.rdata, o.mis, o.rsp_cyc, e.rdata, e.mis, e.rsp_cyc); end
  endtask

  task automatic test_reset_mid_beat;
    bit seen;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_addr = 32'h500; i_req_we = 1'b0; i_req_size = 2'd2;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL t6_cyc_before got %b want 1", o_wb_cyc); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL t6_abort got cyc=%b ready=%b want 0 1", o_wb_cyc, o_req_ready); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_wb_ack = 1'b1;
      @(negedge i_clk);
      if (o_rsp_valid || o_wb_cyc) seen = 1'b1;
    end
    i_wb_ack = 1'b0;
    checks++; if (seen !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL t6_no_rsp got seen=%b ready=%b want 0 1", seen, o_req_ready); end
  endtask

  task automatic test_random_back_to_back;
    obs_t o, e;
    logic [31:0] addr, wd, r0, r1;
    logic [1:0] sz;
    logic we, sg;
    int d0, d1;
    for (int i = 0; i < 150; i++) begin
      addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      wd = $urandom; r0 = $urandom; r1 = $urandom;
      d0 = $urandom_range(0, 5); d1 = $urandom_range(0, 5);
      run_req(addr, we, sz, sg, wd, r0, r1, d0, d1, o);
      e = model(addr, we, sz, sg, wd, r0, r1, d0, d1);
      checks++; if (o.nbeats !== e.nbeats || o.adr !== e.adr || o.sel !== e.sel || o.we !== e.we) begin
        errors++; $display("FAIL rnd%0d_beats got n=%0d adr=%h sel=%b we=%b want n=%0d adr=%h sel=%b we=%b",
                           i, o.nbeats, o.adr, o.sel, o.we, e.nbeats, e.adr, e.sel, e.we); end
      checks++; if ((o.dat[0] & lmask(e.sel[0])) !== e.dat[0] || (o.dat[1] & lmask(e.sel[1])) !== e.dat[1]) begin
        errors++; $display("FAIL rnd%0d_dat got %h want %h (enabled lanes)", i, o.dat, e.dat); end
      checks++; if (o.cyc_cnt !== e.cyc_cnt || o.rsp_cyc !== e.rsp_cyc) begin
        errors++; $display("FAIL rnd%0d_timing got cyc=%0d rsp=%0d want cyc=%0d rsp=%0d", i, o.cyc_cnt, o.rsp_cyc, e.cyc_cnt, e.rsp_cyc); end
      checks++; if (o.rdata !== e.rdata || o.err !== e.err || o.mis !== e.mis) begin
        errors++; $display("FAIL rnd%0d_rsp got %h err=%b mis=%b want %h err=%b mis=%b", i, o.rdata, o.err, o.mis, e.rdata, e.err, e.mis); end
      checks++; if (o.ready_acc !== 1'b1 || o.ready_after !== 1'b1 || o.glitch !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_proto got ready=%b/%b glitch=%b want 1/1 0", i, o.ready_acc, o.ready_after, o.glitch); end
    end
  endtask

  initial begin
    test_reset;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    test_load_byte_signed;
    test_store_half;
    test_misalign;
    test_timeout;
    test_illegal_size;
    test_wrap;
    test_reset_mid_beat;
    test_random_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
